// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: shares one combinational ALU between two requesters.
// Flow per transaction: accept (IDLE) -> drive ALU from registers (EXEC) -> hold response (RESP).
// Optional build macro: ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins ties)
// instead of the default round-robin arbitration.
module alu_arbiter_ctrl #(
    parameter int unsigned N       = 32,
    parameter int unsigned NUM_OPS = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [N-1:0] rsp0_result,
    output logic [3:0]   rsp0_flags,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp1_result,
    output logic [3:0]   rsp1_flags,
    output logic         rsp1_err,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         busy,
    output logic         grant_id
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t       state_q, state_d;
    logic         grant_q;
    logic [N-1:0] a_q, b_q;
    logic [3:0]   ctrl_q;
    logic [N-1:0] res0_q, res1_q;
    logic [3:0]   flags0_q, flags1_q;
    logic         err0_q, err1_q;
    logic         winner;
    logic         accept;
    logic         illegal;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Requester granted most recently; resets to 1 so req0 wins the first tie.
    logic         last_grant_q;
`endif

    // Out-of-range op codes are flagged and the ALU output is discarded.
    assign illegal = 32'(ctrl_q) >= NUM_OPS;

    // Arbitration winner; only meaningful when at least one request is valid.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_grant_q;
`endif
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Next-state logic plus handshake outputs.
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        case (state_q)
            StIdle: begin
                req0_ready = req0_valid && !winner;
                req1_ready = req1_valid && winner;
                accept     = req0_valid || req1_valid;
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                rsp0_valid = !grant_q;
                rsp1_valid = grant_q;
                if (grant_q ? rsp1_ready : rsp0_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            grant_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            flags0_q <= '0;
            flags1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= winner;
                a_q     <= winner ? req1_a  : req0_a;
                b_q     <= winner ? req1_b  : req0_b;
                ctrl_q  <= winner ? req1_op : req0_op;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_grant_q <= winner;
`endif
            end
            if (state_q == StExec) begin
                if (grant_q) begin
                    res1_q   <= illegal ? '0 : alu_result;
                    flags1_q <= illegal ? '0 : alu_flags;
                    err1_q   <= illegal;
                end else begin
                    res0_q   <= illegal ? '0 : alu_result;
                    flags0_q <= illegal ? '0 : alu_flags;
                    err0_q   <= illegal;
                end
            end
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = ctrl_q;
    assign rsp0_result = res0_q;
    assign rsp0_flags  = flags0_q;
    assign rsp0_err    = err0_q;
    assign rsp1_result = res1_q;
    assign rsp1_flags  = flags1_q;
    assign rsp1_err    = err1_q;
    assign busy        = state_q != StIdle;
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Self-checking bench for alu_arbiter_ctrl with a behavioural ALU and per-requester scoreboards.
// Honours ALU_ARB_FIXED_PRIO_EN when the build defines it.
module tb_alu_arbiter_ctrl;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_flags, rsp1_flags;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl, alu_flags;
    logic        busy, grant_id;
    logic [35:0] alu_out;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        logic        err;
    } exp_t;

    typedef struct {
        logic        rdy0, rdy1, v0, v1, e0, e1, busy, gid;
        logic [31:0] r0, r1, aa, ab;
        logic [3:0]  f0, f1, ac;
    } snap_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_arbiter_ctrl #(.N(32), .NUM_OPS(11)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .grant_id(grant_id)
    );

    // Behavioural ALU: {N,Z,C,V, result}; illegal codes return deliberate garbage.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[31:0];
                c = ~w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    r = a << b[4:0];
            4'd7:    r = a >> b[4:0];
            4'd8:    r = $signed(a) >>> b[4:0];
            4'd9:    r = ~(a | b);
            4'd10:   r = b;
            default: return {4'hF, a ^ b ^ 32'h5A5A_0001};
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    assign alu_out    = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_result = alu_out[31:0];
    assign alu_flags  = alu_out[35:32];

    function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] op);
        exp_t        e;
        logic [35:0] o;
        o = alu_fn(a, b, op);
        if (op >= 4'd11) begin
            e.res = '0;
            e.fl  = '0;
            e.err = 1'b1;
        end else begin
            e.res = o[31:0];
            e.fl  = o[35:32];
            e.err = 1'b0;
        end
        return e;
    endfunction

    // Capture all outputs mid-cycle, then advance to just after the next rising edge.
    task automatic sample(output snap_t s);
        @(negedge clk);
        s.rdy0 = req0_ready;  s.rdy1 = req1_ready;
        s.v0   = rsp0_valid;  s.v1   = rsp1_valid;
        s.e0   = rsp0_err;    s.e1   = rsp1_err;
        s.r0   = rsp0_result; s.r1   = rsp1_result;
        s.f0   = rsp0_flags;  s.f1   = rsp1_flags;
        s.busy = busy;        s.gid  = grant_id;
        s.aa   = alu_a;       s.ab   = alu_b;      s.ac = alu_ctrl;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(input bit id, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '{res: 'x, fl: 'x, err: 1'bx};
        if (!id) begin
            if (q0.size() == 0) ok = 1'b0;
            else e = q0.pop_front();
        end else begin
            if (q1.size() == 0) ok = 1'b0;
            else e = q1.pop_front();
        end
    endtask

    task automatic test_reset();
        snap_t s;
        reset = 1'b1;
        sample(s);
        sample(s);
        checks++;
        if ({s.busy, s.gid, s.rdy0, s.rdy1, s.v0, s.v1, s.e0, s.e1} !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctrl got %b required 00000000",
                     {s.busy, s.gid, s.rdy0, s.rdy1, s.v0, s.v1, s.e0, s.e1});
        end
        checks++;
        if ({s.r0, s.r1, s.f0, s.f1} !== 72'd0) begin
            failures++;
            $display("FAIL reset_rsp got r0=%h r1=%h f0=%h f1=%h required all 0",
                     s.r0, s.r1, s.f0, s.f1);
        end
        checks++;
        if ({s.aa, s.ab, s.ac} !== 68'd0) begin
            failures++;
            $display("FAIL reset_alu got a=%h b=%h ctrl=%h required all 0", s.aa, s.ab, s.ac);
        end
        reset = 1'b0;
        sample(s);
        checks++;
        if (s.busy !== 1'b0 || s.v0 !== 1'b0 || s.v1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b v0=%b v1=%b required 0 0 0", s.busy, s.v0, s.v1);
        end
    endtask

    task automatic test_single();
        snap_t s;
        exp_t  e;
        bit    ok;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'd0;
        sample(s);
        checks++;
        if (s.rdy0 !== 1'b1 || s.rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL single_accept got rdy0=%b rdy1=%b required 1 0", s.rdy0, s.rdy1);
        end
        q0.push_back(mk_exp(req0_a, req0_b, req0_op));
        req0_valid = 1'b0;
        sample(s);
        checks++;
        if (s.v0 !== 1'b0 || s.v1 !== 1'b0 || s.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_exec got v0=%b v1=%b busy=%b required 0 0 1", s.v0, s.v1, s.busy);
        end
        sample(s);
        checks++;
        if (s.v0 !== 1'b1 || s.v1 !== 1'b0) begin
            failures++;
            $display("FAIL single_latency got v0=%b v1=%b required 1 0", s.v0, s.v1);
        end
        pop_exp(1'b0, e, ok);
        checks++;
        if (!ok || s.r0 !== e.res || s.f0 !== e.fl || s.e0 !== e.err || s.r0 !== 32'd8) begin
            failures++;
            $display("FAIL single_rsp0 got res=%h fl=%h err=%b required res=%h fl=%h err=%b",
                     s.r0, s.f0, s.e0, e.res, e.fl, e.err);
        end
        sample(s);
        checks++;
        if (s.busy !== 1'b0 || s.v0 !== 1'b0) begin
            failures++;
            $display("FAIL single_done got busy=%b v0=%b required 0 0", s.busy, s.v0);
        end
    endtask

    task automatic test_round_robin();
        snap_t s;
        exp_t  e;
        bit    ok;
        bit    exp_g;
        int    gcount   = 0;
        int    last_acc = -1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 10));
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 10));
        for (int cyc = 0; cyc < 12; cyc++) begin
            sample(s);
            if (s.rdy0 || s.rdy1) begin
                exp_g = FIXED ? 1'b0 : ((gcount % 2) == 1);
                checks++;
                if (s.rdy1 !== exp_g || s.rdy0 !== !exp_g) begin
                    failures++;
                    $display("FAIL rr_grant[%0d] got rdy0=%b rdy1=%b required grant %0d",
                             gcount, s.rdy0, s.rdy1, exp_g);
                end
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 3) begin
                        failures++;
                        $display("FAIL rr_throughput got %0d cycles required 3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                gcount++;
                if (s.rdy1) begin
                    q1.push_back(mk_exp(req1_a, req1_b, req1_op));
                    req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 10));
                end else begin
                    q0.push_back(mk_exp(req0_a, req0_b, req0_op));
                    req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 10));
                end
            end
            if (s.v0 && s.v1) begin
                checks++;
                failures++;
                $display("FAIL rr_both_rsp got v0=1 v1=1 required at most one");
            end
            if (s.v0) begin
                pop_exp(1'b0, e, ok);
                checks++;
                if (!ok || s.r0 !== e.res || s.f0 !== e.fl || s.e0 !== e.err) begin
                    failures++;
                    $display("FAIL rr_rsp0 got res=%h fl=%h err=%b required res=%h fl=%h err=%b",
                             s.r0, s.f0, s.e0, e.res, e.fl, e.err);
                end
            end
            if (s.v1) begin
                pop_exp(1'b1, e, ok);
                checks++;
                if (!ok || s.r1 !== e.res || s.f1 !== e.fl || s.e1 !== e.err) begin
                    failures++;
                    $display("FAIL rr_rsp1 got res=%h fl=%h err=%b required res=%h fl=%h err=%b",
                             s.r1, s.f1, s.e1, e.res, e.fl, e.err);
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (gcount != 4 || q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL rr_count got grants=%0d pending=%0d/%0d required 4 0/0",
                     gcount, q0.size(), q1.size());
        end
    endtask

    task automatic test_stall();
        snap_t       s;
        exp_t        e;
        bit          ok;
        bit          first = 1'b1;
        logic [31:0] held;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'hDEAD_0000; req0_b = 32'h0000_BEEF; req0_op = 4'd3;
        sample(s);
        checks++;
        if (s.rdy0 !== 1'b1) begin
            failures++;
            $display("FAIL stall_accept got rdy0=%b required 1", s.rdy0);
        end
        q0.push_back(mk_exp(req0_a, req0_b, req0_op));
        held = q0[0].res;
        sample(s);
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd7;  req0_op = 4'd1;
        req1_valid = 1'b1; req1_a = 32'd9;   req1_b = 32'd11; req1_op = 4'd5;
        for (int i = 0; i < 10; i++) begin
            sample(s);
            checks++;
            if (s.v0 !== 1'b1 || s.r0 !== held || s.rdy0 !== 1'b0 || s.rdy1 !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] got v0=%b res=%h rdy=%b%b required 1 %h 00",
                         i, s.v0, s.r0, s.rdy0, s.rdy1, held);
            end
        end
        rsp0_ready = 1'b1;
        sample(s);
        pop_exp(1'b0, e, ok);
        checks++;
        if (!ok || s.v0 !== 1'b1 || s.r0 !== e.res || s.f0 !== e.fl || s.e0 !== e.err) begin
            failures++;
            $display("FAIL stall_rsp0 got v0=%b res=%h fl=%h required 1 %h %h",
                     s.v0, s.r0, s.f0, e.res, e.fl);
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            sample(s);
            if (first) begin
                checks++;
                if (s.rdy0 !== FIXED || s.rdy1 !== !FIXED) begin
                    failures++;
                    $display("FAIL stall_resume got rdy0=%b rdy1=%b required %b %b",
                             s.rdy0, s.rdy1, FIXED, !FIXED);
                end
                first = 1'b0;
            end
            if (s.rdy0) begin
                q0.push_back(mk_exp(req0_a, req0_b, req0_op));
                req0_valid = 1'b0;
            end
            if (s.rdy1) begin
                q1.push_back(mk_exp(req1_a, req1_b, req1_op));
                req1_valid = 1'b0;
            end
            if (s.v0) begin
                pop_exp(1'b0, e, ok);
                checks++;
                if (!ok || s.r0 !== e.res || s.f0 !== e.fl || s.e0 !== e.err) begin
                    failures++;
                    $display("FAIL stall_drain0 got res=%h fl=%h required %h %h",
                             s.r0, s.f0, e.res, e.fl);
                end
            end
            if (s.v1) begin
                pop_exp(1'b1, e, ok);
                checks++;
                if (!ok || s.r1 !== e.res || s.f1 !== e.fl || s.e1 !== e.err) begin
                    failures++;
                    $display("FAIL stall_drain1 got res=%h fl=%h required %h %h",
                             s.r1, s.f1, e.res, e.fl);
                end
            end
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || req0_valid || req1_valid) begin
            failures++;
            $display("FAIL stall_pending got q=%0d/%0d valid=%b%b required 0/0 00",
                     q0.size(), q1.size(), req0_valid, req1_valid);
        end
    endtask

    task automatic test_illegal_op();
        snap_t s;
        exp_t  e;
        bit    ok;
        logic  exp_err;
        for (int k = 0; k < 2; k++) begin
            req1_valid = 1'b1;
            req1_a     = $urandom | 32'h1;
            req1_b     = $urandom;
            req1_op    = (k == 0) ? 4'hF : 4'd0;
            exp_err    = (k == 0);
            sample(s);
            checks++;
            if (s.rdy1 !== 1'b1) begin
                failures++;
                $display("FAIL illegal_accept[%0d] got rdy1=%b required 1", k, s.rdy1);
            end
            q1.push_back(mk_exp(req1_a, req1_b, req1_op));
            req1_valid = 1'b0;
            sample(s);
            sample(s);
            pop_exp(1'b1, e, ok);
            checks++;
            if (!ok || s.v1 !== 1'b1 || s.e1 !== exp_err || s.r1 !== e.res || s.f1 !== e.fl) begin
                failures++;
                $display("FAIL illegal_rsp1[%0d] got v1=%b err=%b res=%h fl=%h required 1 %b %h %h",
                         k, s.v1, s.e1, s.r1, s.f1, exp_err, e.res, e.fl);
            end
            sample(s);
        end
    endtask

    task automatic test_reset_mid_op();
        snap_t s;
        exp_t  e;
        bit    ok;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd0;
        sample(s);
        checks++;
        if (s.rdy0 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_accept got rdy0=%b required 1", s.rdy0);
        end
        req0_valid = 1'b0;
        reset = 1'b1;
        sample(s);
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h0F0F_0F0F; req0_op = 4'd2;
        req1_valid = 1'b1; req1_a = 32'd3;         req1_b = 32'd4;         req1_op = 4'd0;
        sample(s);
        checks++;
        if (s.v0 !== 1'b0 || s.v1 !== 1'b0 || s.busy !== 1'b0 || s.rdy0 !== 1'b1 || s.rdy1 !== 1'b0)
        begin
            failures++;
            $display("FAIL midrst_after got v=%b%b busy=%b rdy=%b%b required 00 0 10",
                     s.v0, s.v1, s.busy, s.rdy0, s.rdy1);
        end
        q0.push_back(mk_exp(req0_a, req0_b, req0_op));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sample(s);
        sample(s);
        pop_exp(1'b0, e, ok);
        checks++;
        if (!ok || s.v0 !== 1'b1 || s.r0 !== e.res || s.f0 !== e.fl || s.e0 !== e.err) begin
            failures++;
            $display("FAIL midrst_rsp0 got v0=%b res=%h fl=%h required 1 %h %h",
                     s.v0, s.r0, s.f0, e.res, e.fl);
        end
        sample(s);
        checks++;
        if (s.v0 !== 1'b0 || s.v1 !== 1'b0 || s.busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_extra got v=%b%b busy=%b required 00 0", s.v0, s.v1, s.busy);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_illegal_op();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
